// File: rtl/attn_pkg.sv
// Shared types and defaults for the attention-score sequencer.
// Optional build macro: ATTN_SEQ_TIMEOUT_EN (see attn_score_sequencer.sv).
package attn_pkg;

    // Sequencer FSM states, 2-bit encoded.
    typedef enum logic [1:0] {
        S_LOAD_Q = 2'd0,
        S_LOAD_K = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUT    = 2'd3
    } attn_seq_state_t;

    localparam int ATTN_DW           = 8;
    localparam int ATTN_NUM_FEAT_DEF = 4;
    localparam int ATTN_NUM_KEYS_DEF = 4;

endpackage

// File: rtl/attn_mod_counter.sv
// Modulo-(MAX+1) counter: increments on inc, wraps to 0 after MAX,
// clr has priority over inc. Width is $clog2-sized, minimum 1 bit.
module attn_mod_counter #(
    parameter int MAX = 3,
    parameter int W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    assign at_max = (cnt == W'(MAX));

    // Count register with synchronous active-low reset.
    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= at_max ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/attn_score_sequencer.sv
// Sequences the shared 8-bit signed MAC for NUM_FEAT-term dot products.
// Input: interleaved q/k byte stream (vld/rdy). Output: one score per
// dot product (vld/rdy), m_last on the NUM_KEYS-th score of each row.
// Optional build macro: ATTN_SEQ_TIMEOUT_EN adds a sticky err output and
// an idle timeout (parameter TIMEOUT) that aborts a stalled partial score.
module attn_score_sequencer
    import attn_pkg::*;
#(
    parameter int NUM_FEAT = ATTN_NUM_FEAT_DEF,
    parameter int NUM_KEYS = ATTN_NUM_KEYS_DEF,
    parameter int MAC_LAT  = 1
`ifdef ATTN_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 255
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ATTN_DW-1:0] s_data,
    input  logic               s_vld,
    output logic               s_rdy,
    output logic [ATTN_DW-1:0] mac_a,
    output logic [ATTN_DW-1:0] mac_b,
    output logic               mac_en,
    output logic               mac_clr,
    input  logic [ATTN_DW-1:0] mac_result,
    output logic [ATTN_DW-1:0] m_data,
    output logic               m_vld,
    input  logic               m_rdy,
    output logic               m_last,
`ifdef ATTN_SEQ_TIMEOUT_EN
    output logic               err,
`endif
    output logic               busy
);

    localparam int FEAT_W  = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int KEY_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    attn_seq_state_t state_q, state_d;

    logic [FEAT_W-1:0]  feat_cnt;
    logic               feat_at_max;
    logic               feat_inc;
    logic [KEY_W-1:0]   key_cnt;
    logic               key_at_max;
    logic               key_inc;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               drain_done;
    logic [ATTN_DW-1:0] q_hold;
    logic               s_xfer;
    logic               m_xfer;
    logic               timeout_hit;

    assign s_xfer = s_vld & s_rdy;
    assign m_xfer = m_vld & m_rdy;
    assign busy   = !((state_q == S_LOAD_Q) && (feat_cnt == '0));

    // The drain count is held while the final strobe is still on mac_en, so
    // capture happens MAC_LAT cycles after the MAC consumes the last pair.
    assign drain_done = !mac_en && (drain_cnt == DRAIN_W'(MAC_LAT - 1));

    attn_mod_counter #(.MAX(NUM_FEAT - 1), .W(FEAT_W)) u_feat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (feat_inc),
        .clr    (timeout_hit),
        .cnt    (feat_cnt),
        .at_max (feat_at_max)
    );

    attn_mod_counter #(.MAX(NUM_KEYS - 1), .W(KEY_W)) u_key_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (key_inc),
        .clr    (1'b0),
        .cnt    (key_cnt),
        .at_max (key_at_max)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LOAD_Q;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, input ready and counter strobes.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        s_rdy    = 1'b0;
        feat_inc = 1'b0;
        key_inc  = 1'b0;
        case (state_q)
            S_LOAD_Q: begin
                s_rdy = 1'b1;
                if (s_vld) state_d = S_LOAD_K;
            end
            S_LOAD_K: begin
                s_rdy = 1'b1;
                if (s_vld) begin
                    feat_inc = 1'b1;
                    state_d  = feat_at_max ? S_DRAIN : S_LOAD_Q;
                end
            end
            S_DRAIN: begin
                if (drain_done) state_d = S_OUT;
            end
            S_OUT: begin
                if (m_xfer) begin
                    key_inc = 1'b1;
                    state_d = S_LOAD_Q;
                end
            end
            default: state_d = S_LOAD_Q;
        endcase
        if (timeout_hit) state_d = S_LOAD_Q;
    end

    // Operand capture, MAC strobes, drain counting and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_hold    <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            drain_cnt <= '0;
            m_data    <= '0;
            m_vld     <= 1'b0;
            m_last    <= 1'b0;
        end else begin
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            if (state_q == S_LOAD_Q && s_xfer) begin
                q_hold <= s_data;
            end
            if (state_q == S_LOAD_K && s_xfer) begin
                mac_a   <= q_hold;
                mac_b   <= s_data;
                mac_en  <= 1'b1;
                mac_clr <= (feat_cnt == '0);
            end
            if (state_q != S_DRAIN) begin
                drain_cnt <= '0;
            end else if (!mac_en && !drain_done) begin
                drain_cnt <= drain_cnt + DRAIN_W'(1);
            end
            if (state_q == S_DRAIN && drain_done) begin
                m_data <= mac_result;
                m_vld  <= 1'b1;
                m_last <= key_at_max;
            end
            if (m_xfer) begin
                m_vld  <= 1'b0;
                m_last <= 1'b0;
            end
        end
    end

`ifdef ATTN_SEQ_TIMEOUT_EN
    logic [7:0] idle_cnt;
    logic       idle_cond;

    assign idle_cond = !s_vld && ((state_q == S_LOAD_K) ||
                                  (state_q == S_LOAD_Q && feat_cnt != '0));
    assign timeout_hit = idle_cond && (idle_cnt == 8'(TIMEOUT - 1));

    // Idle counter and sticky error flag for a stalled partial score.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (!idle_cond || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 8'd1;
            end
            if (timeout_hit) err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_attn_score_sequencer.sv
// Directed bench for attn_score_sequencer with a behavioural MAC datapath.
// Build with ATTN_SEQ_TIMEOUT_EN to also exercise the timeout/err path.
module tb_attn_score_sequencer;
    import attn_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_vld = 1'b0;
    logic       s_rdy;
    logic [7:0] mac_a, mac_b;
    logic       mac_en, mac_clr;
    logic [7:0] mac_result;
    logic [7:0] m_data;
    logic       m_vld;
    logic       m_rdy = 1'b0;
    logic       m_last;
    logic       busy;
`ifdef ATTN_SEQ_TIMEOUT_EN
    logic       err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    attn_score_sequencer #(
        .NUM_FEAT (4),
        .NUM_KEYS (4),
        .MAC_LAT  (1)
`ifdef ATTN_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT  (8)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_vld      (s_vld),
        .s_rdy      (s_rdy),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .mac_result (mac_result),
        .m_data     (m_data),
        .m_vld      (m_vld),
        .m_rdy      (m_rdy),
        .m_last     (m_last),
`ifdef ATTN_SEQ_TIMEOUT_EN
        .err        (err),
`endif
        .busy       (busy)
    );

    // MAC datapath model: one-cycle latency, Q2.12 sum scaled by 2^-9.
    // The accumulator is not reset, like a real datapath register.
    logic signed [17:0] acc = '0;
    always @(posedge clk) begin
        if (mac_en)
            acc <= (mac_clr ? 18'sd0 : acc) + 18'($signed(mac_a) * $signed(mac_b));
    end
    assign mac_result = acc[16:9];

    // Strobe monitor.
    int         en_cnt = 0;
    int         clr_cnt = 0;
    logic       first_clr = 1'b0;
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;
    always @(posedge clk) begin
        if (rst_n && mac_en) begin
            if (en_cnt == 0) first_clr = mac_clr;
            en_cnt  = en_cnt + 1;
            if (mac_clr) clr_cnt = clr_cnt + 1;
            last_a  = mac_a;
            last_b  = mac_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        en_cnt = 0;
        clr_cnt = 0;
        first_clr = 1'b0;
    endtask

    // Called at a negedge; offers one byte and returns at the negedge after it is taken.
    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!s_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_rdy) check("send_rdy_timeout", 32'(s_rdy), 32'd1);
        s_data = b;
        s_vld  = 1'b1;
        @(negedge clk);
        s_vld  = 1'b0;
    endtask

    // Sends four q/k pairs (optional random gaps) and waits for m_vld.
    task automatic do_score(input logic [7:0] q, input logic [7:0] k, input bit gaps,
                            output logic [7:0] data, output logic last);
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            send(q);
            if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
            send(k);
            if (gaps && i < 3) repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        while (!m_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("score_vld", 32'(m_vld), 32'd1);
        data = m_data;
        last = m_last;
    endtask

    initial begin
        logic [7:0] d;
        logic       l;
        int         stable_bad;
        int         en_before;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_rdy",   32'(s_rdy),   32'd1);
        check("rst_mac_en",  32'(mac_en),  32'd0);
        check("rst_mac_clr", 32'(mac_clr), 32'd0);
        check("rst_mac_a",   32'(mac_a),   32'd0);
        check("rst_mac_b",   32'(mac_b),   32'd0);
        check("rst_m_vld",   32'(m_vld),   32'd0);
        check("rst_m_last",  32'(m_last),  32'd0);
        check("rst_m_data",  32'(m_data),  32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Score 1: back-to-back 0x40/0x40, exact output latency.
        clear_mon();
        m_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(8'h40);
            if (i == 0) check("s1_busy", 32'(busy), 32'd1);
            send(8'h40);
        end
        check("s1_vld_c1", 32'(m_vld), 32'd0);
        check("s1_s_rdy_drain", 32'(s_rdy), 32'd0);
        @(negedge clk);
        check("s1_vld_c2", 32'(m_vld), 32'd0);
        @(negedge clk);
        check("s1_vld_c3", 32'(m_vld), 32'd1);
        check("s1_data", 32'(m_data), 32'h20);
        check("s1_last", 32'(m_last), 32'd0);
        check("s1_en_cnt", 32'(en_cnt), 32'd4);
        check("s1_clr_cnt", 32'(clr_cnt), 32'd1);
        check("s1_first_clr", 32'(first_clr), 32'd1);
        @(negedge clk);
        check("s1_vld_drop", 32'(m_vld), 32'd0);
        check("s1_s_rdy_back", 32'(s_rdy), 32'd1);

        // Scores 2..5: m_last only on the 4th, wraps on the 5th.
        do_score(8'h40, 8'h40, 1'b0, d, l);
        check("s2_last", 32'(l), 32'd0);
        @(negedge clk);
        do_score(8'h40, 8'h40, 1'b0, d, l);
        check("s3_last", 32'(l), 32'd0);
        @(negedge clk);
        do_score(8'h40, 8'h40, 1'b0, d, l);
        check("s4_last", 32'(l), 32'd1);
        check("s4_data", 32'(d), 32'h20);
        @(negedge clk);
        do_score(8'h40, 8'h40, 1'b0, d, l);
        check("s5_last", 32'(l), 32'd0);
        @(negedge clk);

        // Score 6: output back-pressure for 10 cycles with input offered.
        m_rdy = 1'b0;
        do_score(8'h40, 8'h40, 1'b0, d, l);
        en_before  = en_cnt;
        stable_bad = 0;
        s_data = 8'h11;
        s_vld  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_vld !== 1'b1 || m_data !== 8'h20 || s_rdy !== 1'b0) stable_bad++;
        end
        s_vld = 1'b0;
        check("hold_stable", 32'(stable_bad), 32'd0);
        check("hold_no_strobe", 32'(en_cnt), 32'(en_before));
        m_rdy = 1'b1;
        @(negedge clk);
        check("hold_release", 32'(m_vld), 32'd0);

        // Score 7: random input gaps, negative operand.
        clear_mon();
        do_score(8'hC0, 8'h7F, 1'b1, d, l);
        check("gap_en_cnt", 32'(en_cnt), 32'd4);
        check("gap_mac_a", 32'(last_a), 32'hC0);
        check("gap_mac_b", 32'(last_b), 32'h7F);
        check("gap_data", 32'(d), 32'hC0);
        check("gap_last", 32'(l), 32'd0);
        @(negedge clk);

        // Mid-score reset after 2 pairs, then a fresh score.
        send(8'h40); send(8'h40);
        send(8'h40); send(8'h40);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("abort_no_vld", 32'(m_vld), 32'd0);
        clear_mon();
        do_score(8'h40, 8'h40, 1'b0, d, l);
        check("post_rst_first_clr", 32'(first_clr), 32'd1);
        check("post_rst_data", 32'(d), 32'h20);
        check("post_rst_last", 32'(l), 32'd0);
        @(negedge clk);

`ifdef ATTN_SEQ_TIMEOUT_EN
        // Timeout: q0 then idle in S_LOAD_K.
        check("to_err_init", 32'(err), 32'd0);
        send(8'h40);
        repeat (4) @(negedge clk);
        check("to_err_early", 32'(err), 32'd0);
        repeat (6) @(negedge clk);
        check("to_err_set", 32'(err), 32'd1);
        check("to_idle_state", 32'(busy), 32'd0);
        clear_mon();
        do_score(8'h40, 8'h40, 1'b0, d, l);
        check("to_first_clr", 32'(first_clr), 32'd1);
        check("to_data", 32'(d), 32'h20);
        check("to_err_sticky", 32'(err), 32'd1);
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
